// File: rtl/frame_sequencer.sv
// Frame-level controller: feeds one ROWS x COLS frame into the descriptor pipeline,
// then waits for OUT_COUNT result strobes (or an inactivity timeout) and flags completion.
module frame_sequencer #(
    parameter int ROWS      = 30,
    parameter int COLS      = 30,
    parameter int OUT_COUNT = ROWS * COLS,
    parameter int TIMEOUT   = 4096
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start_i,
    input  logic                           pix_valid_i,
    input  logic [7:0]                     pix_i,
    output logic                           pix_ready_o,
    output logic [7:0]                     grayscale_o,
    output logic                           done_o,
    input  logic                           res_done_i,
    output logic                           busy_o,
    output logic                           frame_done_o,
    output logic                           timeout_o,
    output logic [$clog2(OUT_COUNT+1)-1:0] out_cnt_o
);

    localparam int NPIX = ROWS * COLS;
    localparam int IW   = $clog2(NPIX + 1);
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam int OW   = $clog2(OUT_COUNT + 1);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    state_t        state, state_n;
    logic [IW-1:0] in_cnt;
    logic [TW-1:0] timer;
    logic          accept;
    logic          drain_to;
    logic          frame_start;
    logic          counting;

    assign accept      = (state == FEED) && pix_valid_i;
    assign frame_start = (state == IDLE) && start_i;
    assign counting    = (state == FEED) || (state == DRAIN);
    assign pix_ready_o = (state == FEED);
    assign busy_o      = counting;

    always_comb begin
        state_n  = state;
        drain_to = 1'b0;
        case (state)
            IDLE:  if (start_i) state_n = FEED;
            FEED:  if (accept && in_cnt == IW'(NPIX - 1)) state_n = DRAIN;
            DRAIN: begin
                // A full result count wins over a coincident timeout.
                if (out_cnt_o == OW'(OUT_COUNT)) begin
                    state_n = DONE;
                end else if (!res_done_i && timer == TW'(TIMEOUT - 1)) begin
                    state_n  = DONE;
                    drain_to = 1'b1;
                end
            end
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            in_cnt       <= '0;
            timer        <= '0;
            out_cnt_o    <= '0;
            grayscale_o  <= '0;
            done_o       <= 1'b0;
            frame_done_o <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            state        <= state_n;
            done_o       <= accept;
            frame_done_o <= (state_n == DONE);
            if (accept) grayscale_o <= pix_i;

            if (frame_start) begin
                in_cnt    <= '0;
                timer     <= '0;
                out_cnt_o <= '0;
                timeout_o <= 1'b0;
            end else begin
                if (accept) in_cnt <= in_cnt + 1'b1;
                // Saturate: strobes beyond the expected count are dropped.
                if (counting && res_done_i && out_cnt_o < OW'(OUT_COUNT))
                    out_cnt_o <= out_cnt_o + 1'b1;
                if (state == DRAIN) timer <= res_done_i ? '0 : timer + 1'b1;
                if (drain_to) timeout_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: pixel scoreboard on done_o plus
// cycle-level checks of handshake, drain, timeout, saturation and reset.
module tb_frame_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_i = 1'b0;
    logic       pix_valid_i = 1'b0;
    logic [7:0] pix_i = '0;
    logic       res_done_i = 1'b0;
    logic       pix_ready_o;
    logic [7:0] grayscale_o;
    logic       done_o;
    logic       busy_o;
    logic       frame_done_o;
    logic       timeout_o;
    logic [4:0] out_cnt_o;

    frame_sequencer #(.ROWS(4), .COLS(4), .OUT_COUNT(16), .TIMEOUT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .pix_valid_i  (pix_valid_i),
        .pix_i        (pix_i),
        .pix_ready_o  (pix_ready_o),
        .grayscale_o  (grayscale_o),
        .done_o       (done_o),
        .res_done_i   (res_done_i),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o),
        .timeout_o    (timeout_o),
        .out_cnt_o    (out_cnt_o)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         done_seen = 0;
    int         fd_seen = 0;
    logic [7:0] q[$];
    logic [7:0] last_px = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every done_o strobe pops the next accepted pixel; otherwise grayscale_o holds.
    always @(negedge clk) begin
        if (rst) begin
            last_px = '0;
        end else if (done_o) begin
            done_seen++;
            checks++;
            assert (q.size() > 0) else begin
                errors++;
                $error("FAIL done_extra: got strobe with %0d queued expected none", q.size());
            end
            if (q.size() > 0) begin
                last_px = q.pop_front();
                chk("gray_pix", grayscale_o, last_px);
            end
        end else begin
            chk("gray_hold", grayscale_o, last_px);
        end
        if (!rst && frame_done_o) fd_seen++;
    end

    task automatic start_frame();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("start_busy", busy_o, 1);
        chk("start_ready", pix_ready_o, 1);
        chk("start_cnt", out_cnt_o, 0);
        chk("start_tmo", timeout_o, 0);
        chk("start_fd", frame_done_o, 0);
    endtask

    // gaps: valid toggles 1,0,1,0; start_at: cycle to pulse start_i; strobe_last: result on last accept
    task automatic feed(input int npix, input bit gaps, input int start_at,
                        input bit strobe_last, input int base);
        int n = 0;
        int c = 0;
        while (n < npix) begin
            chk("ready_feed", pix_ready_o, 1);
            pix_valid_i = gaps ? ((c % 2) == 0) : 1'b1;
            pix_i       = 8'(base + n);
            start_i     = (c == start_at);
            res_done_i  = strobe_last && pix_valid_i && (n == npix - 1);
            if (pix_valid_i) begin
                q.push_back(pix_i);
                n++;
            end
            c++;
            step();
        end
        pix_valid_i = 1'b0;
        start_i     = 1'b0;
        res_done_i  = 1'b0;
        if (npix == 16) chk("ready_drop", pix_ready_o, 0);
    endtask

    task automatic results(input int k);
        for (int i = 0; i < k; i++) begin
            res_done_i = 1'b1;
            step();
        end
        res_done_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, f0, n;

        repeat (3) step();
        chk("rst_ready", pix_ready_o, 0);
        chk("rst_gray", grayscale_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_fd", frame_done_o, 0);
        chk("rst_tmo", timeout_o, 0);
        chk("rst_cnt", out_cnt_o, 0);
        rst = 1'b0;
        results(2);
        chk("idle_ignore_res", out_cnt_o, 0);
        chk("idle_busy", busy_o, 0);

        // Nominal frame
        d0 = done_seen; f0 = fd_seen;
        start_frame();
        feed(16, 1'b0, -1, 1'b0, 0);
        chk("drain_busy", busy_o, 1);
        results(15);
        chk("nom_cnt15", out_cnt_o, 15);
        chk("nom_fd_early", frame_done_o, 0);
        results(1);
        chk("nom_cnt16", out_cnt_o, 16);
        chk("nom_fd_m", frame_done_o, 0);
        chk("nom_busy_m", busy_o, 1);
        step();
        chk("nom_fd", frame_done_o, 1);
        chk("nom_busy_done", busy_o, 0);
        chk("nom_tmo", timeout_o, 0);
        step();
        chk("nom_fd_pulse", frame_done_o, 0);
        chk("nom_cnt_hold", out_cnt_o, 16);
        chk("nom_strobes", done_seen - d0, 16);
        chk("nom_fd_count", fd_seen - f0, 1);
        chk("nom_q_empty", q.size(), 0);

        // Timeout after 10 results
        start_frame();
        feed(16, 1'b0, -1, 1'b0, 100);
        results(10);
        n = 0;
        while (!frame_done_o && n < 20) begin
            step();
            n++;
        end
        chk("tmo_latency", n, 8);
        chk("tmo_flag", timeout_o, 1);
        chk("tmo_cnt", out_cnt_o, 10);
        step();
        chk("tmo_sticky", timeout_o, 1);

        // Backpressure gaps, then excess results
        d0 = done_seen;
        start_frame();
        feed(16, 1'b1, -1, 1'b0, 50);
        f0 = fd_seen;
        results(20);
        step();
        chk("exc_cnt", out_cnt_o, 16);
        chk("exc_fd_count", fd_seen - f0, 1);
        chk("exc_busy", busy_o, 0);
        chk("bp_strobes", done_seen - d0, 16);
        chk("bp_q_empty", q.size(), 0);

        // Start ignored in FEED/DRAIN; strobe on last accept counted
        start_frame();
        feed(16, 1'b0, 5, 1'b1, 200);
        chk("coinc_cnt", out_cnt_o, 1);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("drain_start_busy", busy_o, 1);
        chk("drain_start_ready", pix_ready_o, 0);
        chk("drain_start_cnt", out_cnt_o, 1);
        results(14);
        chk("ign_cnt15", out_cnt_o, 15);
        chk("ign_fd_early", frame_done_o, 0);
        results(1);
        chk("ign_cnt16", out_cnt_o, 16);
        step();
        chk("ign_fd", frame_done_o, 1);
        chk("ign_tmo", timeout_o, 0);
        step();

        // Reset mid-FEED
        start_frame();
        feed(5, 1'b0, -1, 1'b1, 30);
        chk("pre_rst_cnt", out_cnt_o, 1);
        chk("pre_rst_done", done_o, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", pix_ready_o, 0);
        chk("mid_rst_gray", grayscale_o, 0);
        chk("mid_rst_done", done_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_fd", frame_done_o, 0);
        chk("mid_rst_tmo", timeout_o, 0);
        chk("mid_rst_cnt", out_cnt_o, 0);
        q.delete();
        step();
        rst = 1'b0;
        step();
        chk("post_rst_busy", busy_o, 0);

        // Nominal frame after reset
        d0 = done_seen;
        start_frame();
        feed(16, 1'b0, -1, 1'b0, 70);
        results(16);
        step();
        chk("post_fd", frame_done_o, 1);
        chk("post_tmo", timeout_o, 0);
        chk("post_cnt", out_cnt_o, 16);
        step();
        chk("post_strobes", done_seen - d0, 16);
        chk("post_q_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Frame-level controller for the median/interpolation/NI/RD/RIU descriptor pipeline. It accepts one grayscale frame of ROWS×COLS pixels from a valid/ready source and re-times it onto the pipeline's `grayscale_i`/`done_i` strobe interface. It then waits for the expected number of RIU result strobes, or an inactivity timeout, and signals frame completion. It is the only block that starts and ends a frame for the pipeline.

## Interface
- `ROWS`, 30, frame height in pixels.
- `COLS`, 30, frame width in pixels.
- `OUT_COUNT`, ROWS*COLS, number of result strobes expected per frame.
- `TIMEOUT`, 4096, maximum number of DRAIN cycles allowed without a result strobe.
- `clk` input 1: single clock; all logic is rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `start_i` input 1: frame start request; sampled only in IDLE.
- `pix_valid_i` input 1: source pixel valid.
- `pix_i` input 8: source pixel.
- `pix_ready_o` output 1: pixel accepted when `pix_valid_i & pix_ready_o`.
- `grayscale_o` output 8: pixel presented to the pipeline.
- `done_o` output 1: one-cycle pixel strobe to the pipeline `done_i`.
- `res_done_i` input 1: result strobe from the final RIU mapping stage.
- `busy_o` output 1: high in FEED and DRAIN.
- `frame_done_o` output 1: one-cycle pulse at end of frame.
- `timeout_o` output 1: sticky flag; frame ended by timeout.
- `out_cnt_o` output $clog2(OUT_COUNT+1): result strobes counted in the current frame.

## Operation
- States are IDLE, FEED, DRAIN and DONE.
- IDLE
  - `pix_ready_o` = 0.
  - `res_done_i` is ignored.
  - `start_i` = 1 → FEED. On that edge, clear the input count, `out_cnt_o`, the timer and `timeout_o`.
- FEED
  - `pix_ready_o` = 1.
  - Each accepted pixel: register `grayscale_o` ← `pix_i`, assert `done_o` on the next cycle, and increment the input count.
  - The accept that makes the input count equal ROWS*COLS → DRAIN on the same edge. `pix_ready_o` is 0 from the following cycle.
  - With no accept, `done_o` = 0 and `grayscale_o` holds its last value.
- DRAIN
  - `pix_ready_o` = 0.
  - The timer increments every cycle and clears to 0 on any `res_done_i`.
  - `out_cnt_o` reaches OUT_COUNT → DONE.
  - Otherwise, timer reaches TIMEOUT−1 with no strobe that cycle → DONE, with `timeout_o` set.
- DONE
  - `frame_done_o` = 1 for exactly this cycle.
  - → IDLE unconditionally.
- Result counting
  - `res_done_i` increments `out_cnt_o` in FEED and DRAIN.
  - `out_cnt_o` saturates at OUT_COUNT; extra strobes are dropped.
  - `out_cnt_o` holds its value in DONE and IDLE until the next start.
- A strobe on the same edge as the FEED→DRAIN transition is counted.
- If OUT_COUNT is reached while still in FEED, DRAIN is still entered and exits on the next cycle. The frame always drains after the last pixel.
- Counter widths are $clog2(ROWS*COLS+1) for the input count and $clog2(TIMEOUT+1) for the timer. No wrap-around is possible.
- `start_i` outside IDLE is ignored; it is not queued.
- Reset asserted mid-frame: state → IDLE immediately and asynchronously, with all counters and outputs cleared. In-flight pipeline data is abandoned; the pipeline shares this `rst`.

## Timing
- Reset values: every output is 0, including `pix_ready_o`, `grayscale_o`, `done_o`, `busy_o`, `frame_done_o`, `timeout_o` and `out_cnt_o`.
- `start_i` high at edge N: FEED from N. `pix_ready_o` and `busy_o` are high in cycle N+1.
- Pixel latency: an accept at edge k gives `grayscale_o` valid with `done_o` = 1 during cycle k+1.
- Strobe rate is one per cycle maximum. Back-to-back accepts give back-to-back `done_o`.
- DRAIN exit on count: `out_cnt_o` reaches OUT_COUNT at edge m → DONE at edge m+1. `frame_done_o` is high in cycle m+1→m+2 and `busy_o` is low in the same cycle.
- `frame_done_o` and `timeout_o` are both registered, and `timeout_o` rises with `frame_done_o`.

## Test plan
- Nominal frame, ROWS=COLS=4, OUT_COUNT=16, TIMEOUT=8: continuous valid, pixels 0..15 → `done_o` high 16 consecutive cycles with `grayscale_o` = 0..15. Then 16 `res_done_i` strobes → one `frame_done_o`, `timeout_o`=0, `out_cnt_o`=16.
- Backpressure gaps: `pix_valid_i` toggling 1,0,1,0 → `done_o` mirrors accepts one cycle later and exactly 16 strobes are issued. `pix_ready_o` drops the cycle after the 16th accept.
- Timeout: only 10 results, then silence → `frame_done_o` 8 cycles after the 10th strobe, `timeout_o`=1, `out_cnt_o`=10. A new `start_i` clears `timeout_o` to 0.
- Excess results: 20 strobes → `out_cnt_o` saturates at 16, one `frame_done_o`. Strobes after DONE are not counted.
- `start_i` pulsed in FEED and in DRAIN → no restart and no change in counts. Result strobe coincident with the 16th pixel accept is counted.
- Reset mid-FEED after 5 pixels → all outputs 0 in the same cycle, state IDLE. The next frame runs nominally.
